wb_arbiter: RTL and testbench



---
 rtl/cpu_pkg.sv | 21 ++
 rtl/wb_hold_slot.sv | 55 +++++
 rtl/wb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the writeback path.
// Holds the default widths, the writeback payload layout and the source ids
// that the arbiter uses to name its two requesters.
package cpu_pkg;

  localparam int unsigned SB_SIZE_WIDTH = 4;
  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned REG_WIDTH     = 5;

  // One completed result on its way to the scoreboard and register file.
  typedef struct packed {
    logic [SB_SIZE_WIDTH-1:0] pos;
    logic [REG_WIDTH-1:0]     rd;
    logic                     we;
    logic [DATA_WIDTH-1:0]    data;
  } wb_payload_t;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LS  = 1'b1;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry holding register between a producing unit and the writeback arbiter.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid_i      producer offers in_payload_i
//   in_payload_i    result being offered
//   in_ready_c_o    combinational: slot empty or draining this cycle
//   drain_i         arbiter grants this slot (only asserted while valid_o)
//   valid_o         slot holds a result
//   payload_o       held result
module wb_hold_slot
  import cpu_pkg::*;
#(
  parameter type payload_t = wb_payload_t
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid_i,
  input  payload_t in_payload_i,
  output logic     in_ready_c_o,
  input  logic     drain_i,
  output logic     valid_o,
  output payload_t payload_o
);

  logic     valid_q, valid_d;
  payload_t payload_q, payload_d;

  // Drain and refill in the same cycle keeps the slot full with the new entry.
  always_comb begin
    in_ready_c_o = !valid_q || drain_i;
    valid_d      = valid_q;
    payload_d    = payload_q;
    if (drain_i) begin
      valid_d = 1'b0;
    end
    if (in_valid_i && in_ready_c_o) begin
      valid_d   = 1'b1;
      payload_d = in_payload_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares the single scoreboard / register-file write port
// between the ALU and the load/store unit. Each source lands in a one-entry
// holding slot; one slot per cycle is granted onto the registered wb_* bus.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   alu_valid/ready/pos/rd/we/data  ALU result handshake (ready combinational)
//   ls_valid/ready/pos/rd/we/data   LS result handshake (ready combinational)
//   wb_valid/pos/rd/we/data      registered writeback bus
// Build option: define WB_ARB_FIXED_PRIO_EN to make the ALU always win
// contention; otherwise grants are round-robin.
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned SB_SIZE_WIDTH = cpu_pkg::SB_SIZE_WIDTH,
  parameter int unsigned DATA_WIDTH    = cpu_pkg::DATA_WIDTH,
  parameter int unsigned REG_WIDTH     = cpu_pkg::REG_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [SB_SIZE_WIDTH-1:0] alu_pos,
  input  logic [REG_WIDTH-1:0]     alu_rd,
  input  logic                     alu_we,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     ls_valid,
  output logic                     ls_ready,
  input  logic [SB_SIZE_WIDTH-1:0] ls_pos,
  input  logic [REG_WIDTH-1:0]     ls_rd,
  input  logic                     ls_we,
  input  logic [DATA_WIDTH-1:0]    ls_data,
  output logic                     wb_valid,
  output logic [SB_SIZE_WIDTH-1:0] wb_pos,
  output logic [REG_WIDTH-1:0]     wb_rd,
  output logic                     wb_we,
  output logic [DATA_WIDTH-1:0]    wb_data
);

  typedef struct packed {
    logic [SB_SIZE_WIDTH-1:0] pos;
    logic [REG_WIDTH-1:0]     rd;
    logic                     we;
    logic [DATA_WIDTH-1:0]    data;
  } payload_t;

  payload_t alu_in, ls_in, alu_hold, ls_hold, sel_c;
  logic     alu_hold_v, ls_hold_v;
  logic     grant_alu_c, grant_ls_c;

  logic                     wb_valid_q, wb_valid_d;
  logic [SB_SIZE_WIDTH-1:0] wb_pos_q, wb_pos_d;
  logic [REG_WIDTH-1:0]     wb_rd_q, wb_rd_d;
  logic                     wb_we_q, wb_we_d;
  logic [DATA_WIDTH-1:0]    wb_data_q, wb_data_d;

  assign alu_in = '{pos: alu_pos, rd: alu_rd, we: alu_we, data: alu_data};
  assign ls_in  = '{pos: ls_pos, rd: ls_rd, we: ls_we, data: ls_data};

  wb_hold_slot #(.payload_t(payload_t)) u_alu_slot (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (alu_valid),
    .in_payload_i (alu_in),
    .in_ready_c_o (alu_ready),
    .drain_i      (grant_alu_c),
    .valid_o      (alu_hold_v),
    .payload_o    (alu_hold)
  );

  wb_hold_slot #(.payload_t(payload_t)) u_ls_slot (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (ls_valid),
    .in_payload_i (ls_in),
    .in_ready_c_o (ls_ready),
    .drain_i      (grant_ls_c),
    .valid_o      (ls_hold_v),
    .payload_o    (ls_hold)
  );

`ifndef WB_ARB_FIXED_PRIO_EN
  logic last_grant_q, last_grant_d;

  // Remember the most recent winner so contention alternates.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_alu_c) begin
      last_grant_d = SRC_ALU;
    end else if (grant_ls_c) begin
      last_grant_d = SRC_LS;
    end
  end

  // Reset to LS so the ALU wins the first contended cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= SRC_LS;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Grant selection, purely from holding-slot state.
  always_comb begin
    grant_alu_c = 1'b0;
    grant_ls_c  = 1'b0;
    if (alu_hold_v && ls_hold_v) begin
`ifdef WB_ARB_FIXED_PRIO_EN
      grant_alu_c = 1'b1;
`else
      grant_alu_c = (last_grant_q == SRC_LS);
      grant_ls_c  = (last_grant_q == SRC_ALU);
`endif
    end else begin
      grant_alu_c = alu_hold_v;
      grant_ls_c  = ls_hold_v;
    end
  end

  // Writeback bus next state; idle cycles keep pos/rd/data to avoid toggling.
  always_comb begin
    sel_c      = grant_alu_c ? alu_hold : ls_hold;
    wb_valid_d = grant_alu_c || grant_ls_c;
    wb_we_d    = 1'b0;
    wb_pos_d   = wb_pos_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (wb_valid_d) begin
      wb_pos_d  = sel_c.pos;
      wb_rd_d   = sel_c.rd;
      wb_data_d = sel_c.data;
      // x0 is hardwired; the slot is still released via wb_valid.
      wb_we_d   = sel_c.we && (sel_c.rd != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_pos_q   <= '0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_pos_q   <= wb_pos_d;
      wb_rd_q    <= wb_rd_d;
      wb_we_q    <= wb_we_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_pos   = wb_pos_q;
  assign wb_rd    = wb_rd_q;
  assign wb_we    = wb_we_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus pushes hand-computed writebacks,
// a negedge monitor pops and compares whenever wb_valid is seen.
module tb_wb_arbiter;
  import cpu_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     alu_valid = 1'b0, alu_ready;
  logic [SB_SIZE_WIDTH-1:0] alu_pos = '0;
  logic [REG_WIDTH-1:0]     alu_rd = '0;
  logic                     alu_we = 1'b0;
  logic [DATA_WIDTH-1:0]    alu_data = '0;
  logic                     ls_valid = 1'b0, ls_ready;
  logic [SB_SIZE_WIDTH-1:0] ls_pos = '0;
  logic [REG_WIDTH-1:0]     ls_rd = '0;
  logic                     ls_we = 1'b0;
  logic [DATA_WIDTH-1:0]    ls_data = '0;
  logic                     wb_valid, wb_we;
  logic [SB_SIZE_WIDTH-1:0] wb_pos;
  logic [REG_WIDTH-1:0]     wb_rd;
  logic [DATA_WIDTH-1:0]    wb_data;

  int checks   = 0;
  int failures = 0;
  wb_payload_t exp_q[$];
  wb_payload_t mon_e;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_pos   (alu_pos),
    .alu_rd    (alu_rd),
    .alu_we    (alu_we),
    .alu_data  (alu_data),
    .ls_valid  (ls_valid),
    .ls_ready  (ls_ready),
    .ls_pos    (ls_pos),
    .ls_rd     (ls_rd),
    .ls_we     (ls_we),
    .ls_data   (ls_data),
    .wb_valid  (wb_valid),
    .wb_pos    (wb_pos),
    .wb_rd     (wb_rd),
    .wb_we     (wb_we),
    .wb_data   (wb_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every writeback must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected: got pos=%0d rd=%0d expected no writeback at %0t",
                 wb_pos, wb_rd, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_pos",  64'(wb_pos),  64'(mon_e.pos));
        chk("wb_rd",   64'(wb_rd),   64'(mon_e.rd));
        chk("wb_we",   64'(wb_we),   64'(mon_e.we));
        chk("wb_data", 64'(wb_data), 64'(mon_e.data));
      end
    end
  end

  function automatic wb_payload_t mk(input int pos, input int rd, input bit we,
                                     input logic [31:0] d);
    wb_payload_t p;
    p.pos  = SB_SIZE_WIDTH'(pos);
    p.rd   = REG_WIDTH'(rd);
    p.we   = we;
    p.data = DATA_WIDTH'(d);
    return p;
  endfunction

  // Expected writeback for a payload: we suppressed when rd is x0.
  function automatic wb_payload_t wbx(input wb_payload_t p);
    wb_payload_t r = p;
    r.we = p.we && (p.rd != '0);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input bit v, input wb_payload_t p);
    alu_valid = v; alu_pos = p.pos; alu_rd = p.rd; alu_we = p.we; alu_data = p.data;
  endtask

  task automatic set_ls(input bit v, input wb_payload_t p);
    ls_valid = v; ls_pos = p.pos; ls_rd = p.rd; ls_we = p.we; ls_data = p.data;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_alu(1'b0, '0);
    set_ls(1'b0, '0);
    step();
    step();
    rst = 1'b0;
  endtask

  bit exp_alu_rdy[6];
  bit exp_ls_rdy[6];

  initial begin
    wb_payload_t a, l;
    int ai, li;
    bit acc_a, acc_l;

    // Reset state
    step();
    chk("rst_wb_valid", 64'(wb_valid), 64'(0));
    chk("rst_wb_we",    64'(wb_we),    64'(0));
    chk("rst_wb_pos",   64'(wb_pos),   64'(0));
    chk("rst_wb_rd",    64'(wb_rd),    64'(0));
    chk("rst_wb_data",  64'(wb_data),  64'(0));
    chk("rst_alu_ready", 64'(alu_ready), 64'(1));
    chk("rst_ls_ready",  64'(ls_ready),  64'(1));
    do_reset();

    // ALU only, single result: two edges of latency, one cycle of wb_valid
    a = mk(3, 5, 1'b1, 32'hDEADBEEF);
    set_alu(1'b1, a);
    exp_q.push_back(wbx(a));
    chk("t1_alu_ready", 64'(alu_ready), 64'(1));
    step();
    set_alu(1'b0, '0);
    chk("t1_ls_ready", 64'(ls_ready), 64'(1));
    chk("t1_wb_early", 64'(wb_valid), 64'(0));
    step();
    chk("t1_wb_valid", 64'(wb_valid), 64'(1));
    chk("t1_ls_ready2", 64'(ls_ready), 64'(1));
    step();
    chk("t1_wb_once", 64'(wb_valid), 64'(0));

    // Simultaneous after reset: ALU first, LS waits one cycle
    do_reset();
    a = mk(1, 2, 1'b1, 32'h11);
    l = mk(9, 4, 1'b1, 32'h22);
    set_alu(1'b1, a);
    set_ls(1'b1, l);
    exp_q.push_back(wbx(a));
    exp_q.push_back(wbx(l));
    step();
    set_alu(1'b0, '0);
    set_ls(1'b0, '0);
    chk("t2_ls_wait",   64'(ls_ready),  64'(0));
    chk("t2_alu_ready", 64'(alu_ready), 64'(1));
    step();
    chk("t2_first_pos", 64'(wb_pos), 64'(1));
    step();
    chk("t2_second_pos", 64'(wb_pos), 64'(9));
    step();
    chk("t2_idle", 64'(wb_valid), 64'(0));

    // Back-to-back ALU, full throughput
    do_reset();
    for (int k = 0; k < 4; k++) begin
      a = mk(k, k + 1, 1'b1, 32'h100 * k);
      set_alu(1'b1, a);
      exp_q.push_back(wbx(a));
      chk("t3_alu_ready", 64'(alu_ready), 64'(1));
      step();
      if (k >= 1) chk("t3_wb_pos", 64'(wb_pos), 64'(k - 1));
    end
    set_alu(1'b0, '0);
    step();
    chk("t3_wb_last_valid", 64'(wb_valid), 64'(1));
    chk("t3_wb_last_pos",   64'(wb_pos),   64'(3));
    step();

    // rd = 0 with we, and a store: slot released, no register write
    do_reset();
    l = mk(6, 0, 1'b1, 32'h55);
    set_ls(1'b1, l);
    exp_q.push_back(mk(6, 0, 1'b0, 32'h55));
    step();
    l = mk(7, 7, 1'b0, 32'h66);
    set_ls(1'b1, l);
    exp_q.push_back(mk(7, 7, 1'b0, 32'h66));
    chk("t4_ls_ready", 64'(ls_ready), 64'(1));
    step();
    set_ls(1'b0, '0);
    step();
    step();

    // Continuous contention for six cycles
    do_reset();
`ifdef WB_ARB_FIXED_PRIO_EN
    exp_alu_rdy = '{1, 1, 1, 1, 1, 1};
    exp_ls_rdy  = '{1, 0, 0, 0, 0, 0};
    for (int k = 0; k < 6; k++) exp_q.push_back(mk(k, k + 1, 1'b1, 32'hA000 + k));
    exp_q.push_back(mk(8, 16, 1'b1, 32'hB000));
`else
    exp_alu_rdy = '{1, 1, 0, 1, 0, 1};
    exp_ls_rdy  = '{1, 0, 1, 0, 1, 0};
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(k, k + 1, 1'b1, 32'hA000 + k));
      exp_q.push_back(mk(8 + k, 16 + k, 1'b1, 32'hB000 + k));
    end
    exp_q.push_back(mk(3, 4, 1'b1, 32'hA003));
`endif
    ai = 0;
    li = 0;
    for (int c = 0; c < 6; c++) begin
      set_alu(1'b1, mk(ai, ai + 1, 1'b1, 32'hA000 + ai));
      set_ls(1'b1, mk(8 + li, 16 + li, 1'b1, 32'hB000 + li));
      chk("t5_alu_ready", 64'(alu_ready), 64'(exp_alu_rdy[c]));
      chk("t5_ls_ready",  64'(ls_ready),  64'(exp_ls_rdy[c]));
      acc_a = alu_ready;
      acc_l = ls_ready;
      step();
      if (acc_a) ai++;
      if (acc_l) li++;
    end
    set_alu(1'b0, '0);
    set_ls(1'b0, '0);
    for (int k = 0; k < 4; k++) step();
    chk("t5_drained", 64'(exp_q.size()), 64'(0));

    // Async reset mid-transfer: held results dropped, wb cleared at once
    do_reset();
    set_alu(1'b1, mk(2, 3, 1'b1, 32'hC0));
    set_ls(1'b1, mk(12, 6, 1'b1, 32'hC1));
    step();
    set_alu(1'b0, '0);
    set_ls(1'b0, '0);
    step();
    chk("t6_wb_before", 64'(wb_valid), 64'(1));
    chk("t6_pos_before", 64'(wb_pos), 64'(2));
    #1 rst = 1'b1;
    #1;
    chk("t6_wb_valid_rst", 64'(wb_valid),  64'(0));
    chk("t6_wb_pos_rst",   64'(wb_pos),    64'(0));
    chk("t6_alu_ready",    64'(alu_ready), 64'(1));
    chk("t6_ls_ready",     64'(ls_ready),  64'(1));
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("t6_no_stale", 64'(wb_valid), 64'(0));
    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
